// File: rtl/dds_sine_generator.sv
// rtl/dds_sine_generator.sv - DDS sine source: phase accumulator, quarter-wave LUT, gain stage, ready/valid out.
// Optional cosine output port enabled by DDS_SINE_GENERATOR_COS_OUT_EN.
module dds_sine_generator #(
   parameter int SAMPLE_W = 24,
   parameter int PHASE_W  = 32,
   parameter int LUT_AW   = 10,
   parameter int AMP_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PHASE_W-1:0]  phase_inc,
   input  logic [AMP_W-1:0]    amplitude,
   input  logic                ready,
   output logic                valid,
`ifdef DDS_SINE_GENERATOR_COS_OUT_EN
   output logic [SAMPLE_W-1:0] out_cos,
`endif
   output logic [SAMPLE_W-1:0] out
);

   localparam int LUT_N = 1 << LUT_AW;
   localparam int FS    = (1 << (SAMPLE_W - 1)) - 1;
   localparam logic [LUT_AW:0]  QTR   = {1'b1, {LUT_AW{1'b0}}};
   localparam logic [AMP_W-1:0] UNITY = {1'b1, {(AMP_W-1){1'b0}}};

   // Elaboration-time sine via Taylor series; error is far below half an LSB.
   function automatic logic [SAMPLE_W-1:0] lut_entry(input int i);
      real x, term, sum;
      x    = 1.5707963267948966 * real'(i) / real'(LUT_N);
      term = x;
      sum  = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      return SAMPLE_W'($rtoi(sum * real'(FS) + 0.5));
   endfunction

   logic [SAMPLE_W-1:0] lut [0:LUT_N];

   for (genvar g = 0; g <= LUT_N; g++) begin : g_lut
      assign lut[g] = lut_entry(g);
   end

   function automatic logic signed [SAMPLE_W-1:0] decode(input logic [1:0] q,
                                                         input logic [LUT_AW-1:0] idx);
      logic [LUT_AW:0]     addr;
      logic [SAMPLE_W-1:0] mag;
      addr = q[0] ? (QTR - {1'b0, idx}) : {1'b0, idx};
      mag  = lut[addr];
      return q[1] ? -$signed(mag) : $signed(mag);
   endfunction

   logic                       en;
   logic [PHASE_W-1:0]         acc;
   logic [PHASE_W-1:0]         s1_phase;
   logic                       s1_valid;
   logic signed [SAMPLE_W-1:0] s2_sin;
   logic                       s2_valid;
   logic [1:0]                 q;
   logic [LUT_AW-1:0]          idx;
   logic signed [SAMPLE_W-1:0] sin_val;
   logic [AMP_W-1:0]           gain_eff;
   logic signed [SAMPLE_W+AMP_W:0] prod_sin;
   logic signed [SAMPLE_W+AMP_W:0] scaled_sin;

   assign en = !valid || ready;

   always_comb begin
      q          = s1_phase[PHASE_W-1 -: 2];
      idx        = s1_phase[PHASE_W-3 -: LUT_AW];
      sin_val    = decode(q, idx);
      gain_eff   = (amplitude > UNITY) ? UNITY : amplitude;
      prod_sin   = s2_sin * $signed({1'b0, gain_eff});
      scaled_sin = prod_sin >>> (AMP_W - 1);
   end

`ifdef DDS_SINE_GENERATOR_COS_OUT_EN
   logic signed [SAMPLE_W-1:0] s2_cos;
   logic signed [SAMPLE_W-1:0] cos_val;
   logic signed [SAMPLE_W+AMP_W:0] prod_cos;
   logic signed [SAMPLE_W+AMP_W:0] scaled_cos;

   // Quarter-period offset only bumps the quadrant; the LUT index is shared.
   always_comb begin
      cos_val    = decode(q + 2'd1, idx);
      prod_cos   = s2_cos * $signed({1'b0, gain_eff});
      scaled_cos = prod_cos >>> (AMP_W - 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_cos  <= '0;
         out_cos <= '0;
      end else if (en) begin
         s2_cos  <= cos_val;
         out_cos <= scaled_cos[SAMPLE_W-1:0];
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         s1_phase <= '0;
         s1_valid <= 1'b0;
         s2_sin   <= '0;
         s2_valid <= 1'b0;
         out      <= '0;
         valid    <= 1'b0;
      end else if (en) begin
         acc      <= acc + phase_inc;
         s1_phase <= acc;
         s1_valid <= 1'b1;
         s2_sin   <= sin_val;
         s2_valid <= s1_valid;
         out      <= scaled_sin[SAMPLE_W-1:0];
         valid    <= s2_valid;
      end
   end

endmodule

// File: tb/tb_dds_sine_generator.sv
// tb/tb_dds_sine_generator.sv - directed self-checking bench for dds_sine_generator.
module tb_dds_sine_generator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] phase_inc = '0;
   logic [15:0] amplitude = '0;
   logic        ready = 1'b0;
   logic        valid;
   logic [23:0] out;
`ifdef DDS_SINE_GENERATOR_COS_OUT_EN
   logic [23:0] out_cos;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   dds_sine_generator dut (
      .clk(clk),
      .reset(reset),
      .phase_inc(phase_inc),
      .amplitude(amplitude),
      .ready(ready),
      .valid(valid),
`ifdef DDS_SINE_GENERATOR_COS_OUT_EN
      .out_cos(out_cos),
`endif
      .out(out)
   );

   always #5 clk = ~clk;

   // Holds reset for a cycle with new settings, then releases it just after a falling edge.
   task automatic restart(input logic [31:0] inc, input logic [15:0] amp);
      reset = 1'b1;
      phase_inc = inc;
      amplitude = amp;
      ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_cmp++;
      if (out !== 24'h0) begin n_bad++; $display("FAIL reset_out: got %h expected 000000", out); end
   endtask

   task automatic test_stream(input string name, input logic [31:0] inc, input logic [15:0] amp,
                              input logic [23:0] e0, input logic [23:0] e1,
                              input logic [23:0] e2, input logic [23:0] e3);
      logic [23:0] exp_seq [4];
      exp_seq = '{e0, e1, e2, e3};
      restart(inc, amp);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL %s_latency_early: valid got %b expected 0", name, valid); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++;
         if (valid !== 1'b1 || out !== exp_seq[k % 4]) begin
            n_bad++;
            $display("FAIL %s_sample%0d: got valid=%b out=%h expected valid=1 out=%h", name, k, valid, out, exp_seq[k % 4]);
         end
      end
   endtask

   task automatic test_octant();
      logic [23:0] exp_seq [8];
      exp_seq = '{24'h000000, 24'h5A8279, 24'h7FFFFF, 24'h5A8279,
                  24'h000000, 24'hA57D87, 24'h800001, 24'hA57D87};
      restart(32'h2000_0000, 16'h8000);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out !== exp_seq[k]) begin
            n_bad++;
            $display("FAIL octant_sample%0d: got %h expected %h", k, out, exp_seq[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] exp_seq [4];
      exp_seq = '{24'h000000, 24'h7FFFFF, 24'h000000, 24'h800001};
      restart(32'h4000_0000, 16'h8000);
      repeat (4) @(negedge clk);
      // Sample index 1 (7FFFFF) is now presented.
      ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if (valid !== 1'b1 || out !== 24'h7FFFFF) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got valid=%b out=%h expected valid=1 out=7fffff", k, valid, out);
         end
      end
      ready = 1'b1;
      for (int k = 2; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (valid !== 1'b1 || out !== exp_seq[k % 4]) begin
            n_bad++;
            $display("FAIL stall_resume%0d: got valid=%b out=%h expected %h", k, valid, out, exp_seq[k % 4]);
         end
      end
   endtask

   task automatic test_mid_reset();
      restart(32'h4000_0000, 16'h8000);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (valid !== 1'b0 || out !== 24'h0) begin
         n_bad++;
         $display("FAIL async_reset: got valid=%b out=%h expected valid=0 out=000000", valid, out);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL restart_early: valid got %b expected 0", valid); end
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b1 || out !== 24'h000000) begin
         n_bad++;
         $display("FAIL restart_first: got valid=%b out=%h expected valid=1 out=000000", valid, out);
      end
      @(negedge clk);
      n_cmp++;
      if (out !== 24'h7FFFFF) begin n_bad++; $display("FAIL restart_second: got %h expected 7fffff", out); end
   endtask

   task automatic test_cos();
`ifdef DDS_SINE_GENERATOR_COS_OUT_EN
      logic [23:0] exp_cos [4];
      exp_cos = '{24'h7FFFFF, 24'h000000, 24'h800001, 24'h000000};
      restart(32'h4000_0000, 16'h8000);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++;
         if (valid !== 1'b1 || out_cos !== exp_cos[k % 4]) begin
            n_bad++;
            $display("FAIL cos_sample%0d: got valid=%b out_cos=%h expected %h", k, valid, out_cos, exp_cos[k % 4]);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_stream("quarter", 32'h4000_0000, 16'h8000, 24'h000000, 24'h7FFFFF, 24'h000000, 24'h800001);
      test_stream("half",    32'h4000_0000, 16'h4000, 24'h000000, 24'h3FFFFF, 24'h000000, 24'hC00000);
      test_stream("satgain", 32'h4000_0000, 16'hFFFF, 24'h000000, 24'h7FFFFF, 24'h000000, 24'h800001);
      test_stream("wrap",    32'hC000_0000, 16'h8000, 24'h000000, 24'h800001, 24'h000000, 24'h7FFFFF);
      test_stream("zeroinc", 32'h0000_0000, 16'h8000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
      test_octant();
      test_backpressure();
      test_mid_reset();
      test_cos();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dds_sine_generator.md
Name: dds_sine_generator

Overview:
- Parametrised direct-digital-synthesis sine source; next generation of the fixed-period sine generator.
- Adds runtime frequency (phase increment), runtime amplitude scaling, configurable sample/phase widths and a quarter-wave LUT.
- Streams signed samples over a ready/valid handshake into the audio datapath.

Parameters:
- SAMPLE_W, 24, output sample width (signed two's complement).
- PHASE_W, 32, phase accumulator width; one full sine period spans 2^PHASE_W.
- LUT_AW, 10, quarter-wave LUT index width; the LUT holds 2^LUT_AW+1 entries.
- AMP_W, 16, amplitude input width; unity gain is 2^(AMP_W-1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- phase_inc  input  PHASE_W  phase step per produced sample (unsigned).
- amplitude  input  AMP_W  unsigned gain; gain = min(amplitude, 2^(AMP_W-1)) / 2^(AMP_W-1).
- ready  input  1  downstream accepts the current sample.
- valid  output  1  out holds a valid sample.
- out  output  SAMPLE_W  signed sample.

Behaviour:
- Reset: asynchronous, active-high. While reset is high, the phase accumulator, all pipeline registers, valid and out are 0. Asserting reset mid-stream clears them immediately; the stream restarts from phase 0 after release.
- LUT: entry i = round(sin(pi/2 * i / 2^LUT_AW) * FS), where FS = 2^(SAMPLE_W-1)-1 and i = 0..2^LUT_AW. Initialised at elaboration; read-only.
- Phase decode:
  - q = phase[PHASE_W-1 -: 2]; idx = phase[PHASE_W-3 -: LUT_AW]. Lower phase bits are truncated; there is no interpolation.
  - q=0: +LUT[idx]. q=1: +LUT[2^LUT_AW-idx]. q=2: -LUT[idx]. q=3: -LUT[2^LUT_AW-idx].
- Pipeline: three register stages: phase register -> LUT/sign stage -> scale/output stage (drives out). Per-stage valid bits form a shift chain.
- Advance enable: en = !valid | ready. When en=0, every stage holds, including the phase register.
- Accumulator: on each en, phase <= phase + phase_inc (mod 2^PHASE_W, natural wrap). The first sample emitted after reset is phase 0.
- Latency: with ready=1 from reset release, valid rises after the 3rd rising edge following release. One sample per cycle thereafter.
- Handshake:
  - A sample transfers on a rising edge with valid & ready.
  - While valid & !ready, out and valid are stable.
  - Once valid is 1, it never drops except on reset.
  - No sample is skipped or duplicated.
- Scaling: product = signed_lut * gain_eff, where gain_eff = min(amplitude, 2^(AMP_W-1)). out = product >>> (AMP_W-1), an arithmetic shift that floors toward -inf. Width is SAMPLE_W+AMP_W+1 internally, so no overflow is possible.
- Timing of runtime inputs:
  - phase_inc is sampled at each accumulator advance.
  - amplitude is sampled when a sample enters the scale stage.
  - Changes apply to subsequent samples only; no glitch to the sample held in out.
- phase_inc=0: constant output of the current phase value.

Optional Feature:
- Macro: DDS_SINE_GENERATOR_COS_OUT_EN.
- Defined:
  - Adds output port out_cos [SAMPLE_W-1:0], the same decode at phase + 2^(PHASE_W-2).
  - out_cos uses the same amplitude and the same pipeline timing and handshake as out; shares valid; uses a second LUT read port.
  - Reset value 0.
- Undefined: port absent; a single LUT read port.

Test Plan:
- Quarter step: reset, phase_inc=32'h4000_0000, amplitude=16'h8000, ready=1 -> out = 000000, 7FFFFF, 000000, 800001, repeating; valid rises on the 3rd edge after release.
- Half gain: same with amplitude=16'h4000 -> 000000, 3FFFFF, 000000, C00000. Saturation: amplitude=16'hFFFF gives the same sequence as unity gain.
- Wrap-around: phase_inc=32'hC000_0000, unity gain -> 000000, 800001, 000000, 7FFFFF, repeating.
- Backpressure: drop ready for 10 cycles mid-stream -> valid stays 1 and out stays constant; after ready returns, the next sample follows with none skipped.
- Reset mid-stream: assert reset asynchronously between edges -> valid=0, out=0 immediately; after release the sequence restarts at 000000.
- COS_OUT_EN: quarter-step stimulus -> out_cos = 7FFFFF, 000000, 800001, 000000, in lockstep with out.
